fake_psx: RTL and testbench

FAKE_PSX -- requirements
Module: fake_psx

---
 rtl/fake_psx.sv | 244 ++++++++++++++++++++++++
 tb/tb_fake_psx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fake_psx.sv
// PlayStation-style controller poller: drives att/psx_clk/cmd, shifts in the
// 5-byte reply, and publishes id, buttons and per-frame error status.
module fake_psx #(
    parameter int ACK_TIMEOUT = 32,
    parameter int FRAME_GAP   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power_btn,
    input  logic        data,
    input  logic        ack,
    output logic        psx_clk,
    output logic        cmd,
    output logic        att,
    output logic [15:0] buttons,
    output logic [7:0]  id,
    output logic        frame_done,
    output logic        error,
    output logic        busy
);

    localparam int CNT_MAX = (ACK_TIMEOUT > FRAME_GAP) ? ACK_TIMEOUT : FRAME_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(FRAME_GAP - 1);
    localparam logic [7:0]       MARKER     = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        ATT_SETUP,
        BIT_LOW,
        BIT_HIGH,
        WAIT_ACK,
        ACK_RELEASE,
        RELEASE,
        GAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       r_byte_idx;
    logic [7:0]       r_rx;
    logic [7:0]       r_byte3;
    logic [7:0]       r_id;
    logic [15:0]      r_buttons;
    logic             r_error;
    logic             r_psx_clk;
    logic             r_cmd;
    logic             r_att;
    logic             r_frame_done;
    logic             r_busy;

    state_t           w_state_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic [2:0]       w_bit_n;
    logic [2:0]       w_byte_n;
    logic [7:0]       w_rx_n;
    logic [7:0]       w_byte3_n;
    logic [7:0]       w_id_n;
    logic [15:0]      w_buttons_n;
    logic             w_error_n;
    logic             w_start;
    logic [7:0]       w_rx_shift;
    logic [7:0]       w_cmd_byte;
    logic             w_psx_clk_n;
    logic             w_cmd_n;
    logic             w_att_n;
    logic             w_frame_done_n;
    logic             w_busy_n;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h01;
            3'd1:    return 8'h42;
            default: return 8'h00;
        endcase
    endfunction

    // Controller data arrives LSB first, so each new bit enters at the MSB.
    assign w_rx_shift = {data, r_rx[7:1]};

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_bit_n     = r_bit_idx;
        w_byte_n    = r_byte_idx;
        w_rx_n      = r_rx;
        w_byte3_n   = r_byte3;
        w_id_n      = r_id;
        w_buttons_n = r_buttons;
        w_error_n   = r_error;
        w_start     = 1'b0;

        case (r_state)
            IDLE: begin
                if (power_btn) begin
                    w_start = 1'b1;
                end
            end
            ATT_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_n = BIT_LOW;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            BIT_LOW: begin
                w_state_n = BIT_HIGH;
            end
            BIT_HIGH: begin
                w_rx_n = w_rx_shift;
                if (r_bit_idx == 3'd7) begin
                    w_bit_n = 3'd0;
                    case (r_byte_idx)
                        3'd1: w_id_n = w_rx_shift;
                        3'd2: if (w_rx_shift != MARKER) w_error_n = 1'b1;
                        3'd3: w_byte3_n = w_rx_shift;
                        3'd4: if (!r_error) w_buttons_n = {w_rx_shift, r_byte3};
                        default: ;
                    endcase
                    if (r_byte_idx == 3'd4) begin
                        w_state_n = RELEASE;
                    end else begin
                        w_state_n = WAIT_ACK;
                        w_cnt_n   = '0;
                        w_byte_n  = r_byte_idx + 3'd1;
                    end
                end else begin
                    w_bit_n   = r_bit_idx + 3'd1;
                    w_state_n = BIT_LOW;
                end
            end
            WAIT_ACK: begin
                if (!ack) begin
                    w_state_n = ACK_RELEASE;
                end else if (r_cnt == ACK_LAST) begin
                    w_state_n = RELEASE;
                    w_error_n = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            ACK_RELEASE: begin
                if (ack) begin
                    w_state_n = BIT_LOW;
                end
            end
            RELEASE: begin
                w_state_n = GAP;
                w_cnt_n   = '0;
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    if (power_btn) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_n = IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // The last gap cycle launches the next frame directly so the
        // att-high interval is exactly RELEASE plus FRAME_GAP cycles.
        if (w_start) begin
            w_state_n = ATT_SETUP;
            w_cnt_n   = '0;
            w_bit_n   = 3'd0;
            w_byte_n  = 3'd0;
            w_error_n = 1'b0;
        end
    end

    // NOTE: pins are decoded from the next state and then registered, so they
    // line up with the state they describe and never follow inputs combinationally.
    always_comb begin
        w_cmd_byte     = cmd_byte(w_byte_n);
        w_att_n        = (w_state_n == IDLE) || (w_state_n == RELEASE) || (w_state_n == GAP);
        w_psx_clk_n    = (w_state_n != BIT_LOW);
        w_cmd_n        = 1'b1;
        if ((w_state_n == BIT_LOW) || (w_state_n == BIT_HIGH)) begin
            w_cmd_n = w_cmd_byte[w_bit_n];
        end
        w_frame_done_n = (w_state_n == RELEASE);
        w_busy_n       = !w_att_n;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_byte_idx   <= 3'd0;
            r_rx         <= 8'h00;
            r_byte3      <= 8'h00;
            r_id         <= 8'h00;
            r_buttons    <= 16'hFFFF;
            r_error      <= 1'b0;
            r_psx_clk    <= 1'b1;
            r_cmd        <= 1'b1;
            r_att        <= 1'b1;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_bit_idx    <= w_bit_n;
            r_byte_idx   <= w_byte_n;
            r_rx         <= w_rx_n;
            r_byte3      <= w_byte3_n;
            r_id         <= w_id_n;
            r_buttons    <= w_buttons_n;
            r_error      <= w_error_n;
            r_psx_clk    <= w_psx_clk_n;
            r_cmd        <= w_cmd_n;
            r_att        <= w_att_n;
            r_frame_done <= w_frame_done_n;
            r_busy       <= w_busy_n;
        end
    end

    assign psx_clk    = r_psx_clk;
    assign cmd        = r_cmd;
    assign att        = r_att;
    assign buttons    = r_buttons;
    assign id         = r_id;
    assign frame_done = r_frame_done;
    assign error      = r_error;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fake_psx.sv
// Self-checking bench for fake_psx: a behavioural controller device answers each
// frame with random replies, and expectations come from the protocol rules.
module tb_fake_psx;

    localparam int ACK_TIMEOUT = 32;
    localparam int FRAME_GAP   = 16;
    localparam logic [7:0] CMD_REF [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};

    logic        clk = 1'b0;
    logic        reset;
    logic        power_btn;
    logic        data;
    logic        ack;
    logic        psx_clk;
    logic        cmd;
    logic        att;
    logic [15:0] buttons;
    logic [7:0]  id;
    logic        frame_done;
    logic        error;
    logic        busy;

    fake_psx #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .FRAME_GAP  (FRAME_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .power_btn (power_btn),
        .data      (data),
        .ack       (ack),
        .psx_clk   (psx_clk),
        .cmd       (cmd),
        .att       (att),
        .buttons   (buttons),
        .id        (id),
        .frame_done(frame_done),
        .error     (error),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Controller device state and bus monitor results.
    logic [7:0] dev_resp [5];
    logic [7:0] cap [5];
    bit         dev_ack_on = 1'b1;
    bit         dev_spurious = 1'b0;
    int         dev_byte = 0;
    int         dev_bit = 0;
    int         cap_bytes = 0;
    int         fd_count = 0;
    int         fd_bad = 0;
    int         busy_bad = 0;
    int         hi_run = 0;
    int         lo_run = 0;
    int         last_low = 0;
    int         last_gap = 0;
    int         ack_timer = -1;
    int         ack_low = 0;
    logic       prev_att = 1'b1;
    logic       prev_psx = 1'b1;

    // Expected architectural state of the poller.
    logic [15:0] model_buttons = 16'hFFFF;
    logic [7:0]  model_id = 8'h00;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Device: acts on the falling clk edge, away from the DUT's active edge.
    initial begin
        data = 1'b1;
        ack  = 1'b1;
        forever begin
            @(negedge clk);
            if (busy !== ~att) busy_bad++;
            if (frame_done === 1'b1) begin
                fd_count++;
                if (!(att === 1'b1 && prev_att === 1'b0)) fd_bad++;
            end
            if (att === 1'b1) begin
                if (prev_att === 1'b0) last_low = lo_run;
                hi_run++;
                lo_run = 0;
            end else begin
                if (prev_att === 1'b1) last_gap = hi_run;
                lo_run++;
                hi_run = 0;
            end

            if (att === 1'b1) begin
                dev_byte = 0; dev_bit = 0; data = 1'b1; ack = 1'b1;
                ack_timer = -1; ack_low = 0;
            end else begin
                if (ack_low > 0) begin
                    ack_low--;
                    if (ack_low == 0) ack = 1'b1;
                end else if (ack_timer == 0) begin
                    ack = 1'b0;
                    ack_low = int'($urandom_range(1, 3));
                    ack_timer = -1;
                end else if (ack_timer > 0) begin
                    ack_timer--;
                end

                if (prev_psx === 1'b1 && psx_clk === 1'b0 && dev_byte < 5) begin
                    data = dev_resp[dev_byte][dev_bit];
                    if (dev_spurious && dev_byte == 1 && dev_bit == 3) begin
                        ack = 1'b0;
                        ack_low = 1;
                    end
                end else if (prev_psx === 1'b0 && psx_clk === 1'b1 && dev_byte < 5) begin
                    cap[dev_byte][dev_bit] = cmd;
                    if (dev_bit == 7) begin
                        dev_bit = 0;
                        if (dev_byte < 4 && dev_ack_on) ack_timer = int'($urandom_range(0, 4));
                        dev_byte++;
                        cap_bytes = dev_byte;
                    end else begin
                        dev_bit++;
                    end
                end
            end
            prev_att = att;
            prev_psx = psx_clk;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic random_good_resp();
        for (int k = 0; k < 5; k++) dev_resp[k] = 8'($urandom);
        dev_resp[2] = 8'h5A;
    endtask

    task automatic wait_done(input string tag, input int start_count, input int budget);
        int i = 0;
        while (fd_count == start_count && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, " done"}, 64'(fd_count != start_count), 64'(1));
    endtask

    task automatic expect_frame(input string tag, input bit timed_out);
        logic exp_err;
        int   exp_bytes;
        if (timed_out) begin
            exp_err   = 1'b1;
            exp_bytes = 1;
        end else begin
            exp_err   = (dev_resp[2] != 8'h5A);
            exp_bytes = 5;
            model_id  = dev_resp[1];
            if (!exp_err) model_buttons = {dev_resp[4], dev_resp[3]};
        end
        check({tag, " error"}, error, exp_err);
        check({tag, " id"}, id, model_id);
        check({tag, " buttons"}, buttons, model_buttons);
        check({tag, " bytes"}, cap_bytes, exp_bytes);
        for (int k = 0; k < exp_bytes; k++)
            check($sformatf("%s cmd%0d", tag, k), cap[k], CMD_REF[k]);
    endtask

    task automatic run_frame(input string tag, input bit timed_out);
        int start;
        int i;
        start     = fd_count;
        cap_bytes = 0;
        power_btn = 1'b1;
        i = 0;
        while (busy !== 1'b1 && i < 5) begin
            @(negedge clk);
            i++;
        end
        check({tag, " start"}, busy, 1'b1);
        power_btn = 1'b0;
        wait_done(tag, start, 600);
        tick(FRAME_GAP + 4);
        check({tag, " pulses"}, 64'(fd_count - start), 64'(1));
        expect_frame(tag, timed_out);
    endtask

    initial begin
        int bad;
        int start;
        int i;

        reset = 1'b1;
        power_btn = 1'b0;
        tick(3);
        reset = 1'b0;
        check("rst att", att, 1'b1);
        check("rst psx_clk", psx_clk, 1'b1);
        check("rst cmd", cmd, 1'b1);
        check("rst buttons", buttons, 16'hFFFF);
        check("rst id", id, 8'h00);
        check("rst frame_done", frame_done, 1'b0);
        check("rst error", error, 1'b0);
        check("rst busy", busy, 1'b0);

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (att !== 1'b1 || psx_clk !== 1'b1 || cmd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle quiet", bad, 0);

        // Reference controller reply.
        dev_resp = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF};
        run_frame("ref", 1'b0);
        check("ref buttons const", buttons, 16'hFFFE);

        for (int n = 0; n < 4; n++) begin
            random_good_resp();
            dev_spurious = n[0];
            run_frame($sformatf("rnd%0d", n), 1'b0);
        end
        dev_spurious = 1'b0;

        dev_ack_on = 1'b0;
        random_good_resp();
        run_frame("timeout", 1'b1);
        check("timeout att low", last_low, 2 + 16 + ACK_TIMEOUT);
        dev_ack_on = 1'b1;

        dev_resp = '{8'hFF, 8'h73, 8'h00, 8'h12, 8'h34};
        run_frame("badmark", 1'b0);
        random_good_resp();
        dev_resp[2] = 8'h5A ^ 8'($urandom_range(1, 255));
        run_frame("badrnd", 1'b0);

        // Continuous polling, then power dropped mid-frame.
        random_good_resp();
        cap_bytes = 0;
        start = fd_count;
        power_btn = 1'b1;
        wait_done("cont1", start, 600);
        expect_frame("cont1", 1'b0);
        random_good_resp();
        cap_bytes = 0;
        i = 0;
        while (att !== 1'b0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        tick(2);
        check("cont gap", last_gap, FRAME_GAP + 1);
        tick(20);
        power_btn = 1'b0;
        start = fd_count;
        wait_done("cont2", start, 600);
        tick(FRAME_GAP + 4);
        expect_frame("cont2", 1'b0);
        start = fd_count;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (att !== 1'b1) bad++;
        end
        check("cont stop att", bad, 0);
        check("cont stop pulses", 64'(fd_count - start), 64'(0));

        // Reset in the middle of byte 2.
        random_good_resp();
        power_btn = 1'b1;
        i = 0;
        while (!(dev_byte == 2 && dev_bit == 4) && i < 400) begin
            @(negedge clk);
            i++;
        end
        check("mid reach byte2", 64'(dev_byte == 2), 64'(1));
        reset = 1'b1;
        power_btn = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_buttons = 16'hFFFF;
        model_id = 8'h00;
        check("mid att", att, 1'b1);
        check("mid psx_clk", psx_clk, 1'b1);
        check("mid busy", busy, 1'b0);
        check("mid buttons", buttons, model_buttons);
        check("mid id", id, model_id);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (att !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid idle", bad, 0);

        random_good_resp();
        dev_spurious = 1'b1;
        run_frame("post", 1'b0);

        check("busy tracks att", busy_bad, 0);
        check("frame_done align", fd_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
